// File: rtl/pipe_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_pkg : shared codes and shadow-stage types for pipe_hazard_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] JUMP_NONE = 2'b00;
  localparam logic [1:0] JUMP_J    = 2'b01;
  localparam logic [1:0] JUMP_JAL  = 2'b10;
  localparam logic [1:0] JUMP_JR   = 2'b11;

  localparam logic [1:0] MEMRD_NONE = 2'b00;
  localparam logic [1:0] MEMRD_LW   = 2'b01;
  localparam logic [1:0] MEMRD_LB   = 2'b10;
  localparam logic [1:0] MEMRD_LH   = 2'b11;

  localparam logic [1:0] MEMWR_NONE = 2'b00;

  typedef struct packed {
    logic valid;
    logic regwrite;
    logic is_load;
    logic is_mem;
  } stage_ctrl_t;

  localparam int STAGE_CTRL_W = $bits(stage_ctrl_t);

  // MEM result is younger than WB, so it wins when both match.
  function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic wb_hit);
    if (mem_hit)     return FWD_MEM;
    else if (wb_hit) return FWD_WB;
    else             return FWD_REG;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sat_counter : up-counter that sticks at all-ones, synchronous clear
// Rev 1.0
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl : stall / flush / freeze / forwarding control for the
// 5-stage pipeline, driven by a shadow copy of EX, MEM and WB state.
// Rev 1.0
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_regwrite,
  input  logic [1:0]        id_memread,
  input  logic [1:0]        id_memwrite,
  input  logic [1:0]        id_jump,
  input  logic              ex_branch_taken,
  input  logic              dmem_ready,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              pipe_freeze,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);

  stage_ctrl_t       ex_ctrl_q,  ex_ctrl_d;
  stage_ctrl_t       mem_ctrl_q, mem_ctrl_d;
  stage_ctrl_t       wb_ctrl_q,  wb_ctrl_d;
  logic [REG_AW-1:0] ex_dst_q,   ex_dst_d;
  logic [REG_AW-1:0] mem_dst_q,  mem_dst_d;
  logic [REG_AW-1:0] wb_dst_q,   wb_dst_d;
  logic [REG_AW-1:0] ex_rs_q,    ex_rs_d;
  logic [REG_AW-1:0] ex_rt_q,    ex_rt_d;

  logic        mem_wait;
  logic        load_hit;
  logic        branch_flush;
  logic        load_use;
  logic        jump_flush;
  logic        mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
  stage_ctrl_t id_ctrl;

  always_comb begin
    mem_wait = mem_ctrl_q.valid && mem_ctrl_q.is_mem && !dmem_ready;
    load_hit = ex_ctrl_q.valid && ex_ctrl_q.is_load && (ex_dst_q != '0) &&
               ((ex_dst_q == id_rs) || (id_uses_rt && (ex_dst_q == id_rt)));

    branch_flush = !mem_wait && ex_branch_taken;
    load_use     = !mem_wait && !ex_branch_taken && id_valid && load_hit;
    jump_flush   = !mem_wait && !ex_branch_taken && !load_use &&
                   id_valid && (id_jump != JUMP_NONE);

    pc_write    = !(mem_wait || load_use);
    ifid_write  = !(mem_wait || load_use);
    ifid_flush  = branch_flush || jump_flush;
    idex_bubble = branch_flush || load_use;
    pipe_freeze = mem_wait;
  end

  always_comb begin
    mem_hit_a = mem_ctrl_q.valid && mem_ctrl_q.regwrite && (mem_dst_q != '0) && (mem_dst_q == ex_rs_q);
    mem_hit_b = mem_ctrl_q.valid && mem_ctrl_q.regwrite && (mem_dst_q != '0) && (mem_dst_q == ex_rt_q);
    wb_hit_a  = wb_ctrl_q.valid  && wb_ctrl_q.regwrite  && (wb_dst_q  != '0) && (wb_dst_q  == ex_rs_q);
    wb_hit_b  = wb_ctrl_q.valid  && wb_ctrl_q.regwrite  && (wb_dst_q  != '0) && (wb_dst_q  == ex_rt_q);
    fwd_a     = fwd_sel(mem_hit_a, wb_hit_a);
    fwd_b     = fwd_sel(mem_hit_b, wb_hit_b);
  end

  always_comb begin
    id_ctrl.valid    = id_valid;
    id_ctrl.regwrite = id_regwrite;
    id_ctrl.is_load  = (id_memread != MEMRD_NONE);
    id_ctrl.is_mem   = (id_memread != MEMRD_NONE) || (id_memwrite != MEMWR_NONE);

    ex_ctrl_d  = ex_ctrl_q;
    mem_ctrl_d = mem_ctrl_q;
    wb_ctrl_d  = wb_ctrl_q;
    ex_dst_d   = ex_dst_q;
    mem_dst_d  = mem_dst_q;
    wb_dst_d   = wb_dst_q;
    ex_rs_d    = ex_rs_q;
    ex_rt_d    = ex_rt_q;

    if (mem_wait) begin
      // EX and MEM hold so a pending branch is seen again after the wait.
      wb_ctrl_d = '0;
      wb_dst_d  = '0;
    end else begin
      wb_ctrl_d  = mem_ctrl_q;
      wb_dst_d   = mem_dst_q;
      mem_ctrl_d = ex_ctrl_q;
      mem_dst_d  = ex_dst_q;
      if (branch_flush || load_use) begin
        ex_ctrl_d = '0;
        ex_dst_d  = '0;
        ex_rs_d   = '0;
        ex_rt_d   = '0;
      end else begin
        ex_ctrl_d = id_ctrl;
        ex_dst_d  = id_dst;
        ex_rs_d   = id_rs;
        ex_rt_d   = id_rt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_ctrl_q  <= '0;
      mem_ctrl_q <= '0;
      wb_ctrl_q  <= '0;
      ex_dst_q   <= '0;
      mem_dst_q  <= '0;
      wb_dst_q   <= '0;
      ex_rs_q    <= '0;
      ex_rt_q    <= '0;
    end else begin
      ex_ctrl_q  <= ex_ctrl_d;
      mem_ctrl_q <= mem_ctrl_d;
      wb_ctrl_q  <= wb_ctrl_d;
      ex_dst_q   <= ex_dst_d;
      mem_dst_q  <= mem_dst_d;
      wb_dst_q   <= wb_dst_d;
      ex_rs_q    <= ex_rs_d;
      ex_rt_q    <= ex_rt_d;
    end
  end

  logic stall_inc;
  logic flush_inc;

  assign stall_inc = !pc_write;
  assign flush_inc = branch_flush || jump_flush;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl : directed self-checking bench, 4-bit counters
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rt;
  logic [REG_AW-1:0] id_dst;
  logic              id_regwrite;
  logic [1:0]        id_memread;
  logic [1:0]        id_memwrite;
  logic [1:0]        id_jump;
  logic              ex_branch_taken;
  logic              dmem_ready;
  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              idex_bubble;
  logic              pipe_freeze;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  flush_count;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .id_dst          (id_dst),
    .id_regwrite     (id_regwrite),
    .id_memread      (id_memread),
    .id_memwrite     (id_memwrite),
    .id_jump         (id_jump),
    .ex_branch_taken (ex_branch_taken),
    .dmem_ready      (dmem_ready),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .pipe_freeze     (pipe_freeze),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic ut, input logic [4:0] dst, input logic rw,
                        input logic [1:0] mr, input logic [1:0] mw, input logic [1:0] j);
    id_valid    = v;
    id_rs       = rs;
    id_rt       = rt;
    id_uses_rt  = ut;
    id_dst      = dst;
    id_regwrite = rw;
    id_memread  = mr;
    id_memwrite = mw;
    id_jump     = j;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    dmem_ready = 1'b1;
    ex_branch_taken = 1'b0;
    idle();
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_pc_write",    pc_write,     1);
    chk("rst_ifid_write",  ifid_write,   1);
    chk("rst_ifid_flush",  ifid_flush,   0);
    chk("rst_idex_bubble", idex_bubble,  0);
    chk("rst_freeze",      pipe_freeze,  0);
    chk("rst_fwd_a",       fwd_a,        0);
    chk("rst_fwd_b",       fwd_b,        0);
    chk("rst_stall_cnt",   stall_cycles, 0);
    chk("rst_flush_cnt",   flush_count,  0);

    // lw $8 then add rs=8: one stall cycle, then WB forwarding
    set_id(1, 5'd1, 5'd0, 0, 5'd8, 1, 2'b01, 2'b00, 2'b00);
    #1;
    chk("lw_issue_pc", pc_write, 1);
    tick();
    set_id(1, 5'd8, 5'd2, 1, 5'd10, 1, 2'b00, 2'b00, 2'b00);
    #1;
    chk("lu_pc_write",   pc_write,    0);
    chk("lu_ifid_write", ifid_write,  0);
    chk("lu_bubble",     idex_bubble, 1);
    chk("lu_flush",      ifid_flush,  0);
    tick();
    #1;
    chk("lu_release_pc",     pc_write,     1);
    chk("lu_release_bubble", idex_bubble,  0);
    chk("lu_stall_cnt",      stall_cycles, 1);
    tick();
    set_id(1, 5'd3, 5'd4, 1, 5'd9, 1, 2'b00, 2'b00, 2'b00);
    #1;
    chk("lu_fwd_a_wb", fwd_a, 2'b01);
    chk("lu_fwd_b",    fwd_b, 2'b00);
    tick();

    // add $9 then sub rt=9: MEM forwarding with no stall
    set_id(1, 5'd5, 5'd9, 1, 5'd11, 1, 2'b00, 2'b00, 2'b00);
    #1;
    chk("alu_issue_pc", pc_write, 1);
    tick();
    set_id(1, 5'd6, 5'd7, 1, 5'd0, 1, 2'b00, 2'b00, 2'b00);
    #1;
    chk("alu_fwd_b_mem", fwd_b,    2'b10);
    chk("alu_fwd_a",     fwd_a,    2'b00);
    chk("alu_pc_write",  pc_write, 1);
    tick();
    set_id(1, 5'd1, 5'd0, 1, 5'd12, 1, 2'b00, 2'b00, 2'b00);
    tick();
    #1;
    chk("r0_fwd_b", fwd_b, 2'b00);
    chk("r0_fwd_a", fwd_a, 2'b00);

    // taken branch with a coincident jump: one flush counted
    set_id(1, 5'd0, 5'd0, 0, 5'd0, 0, 2'b00, 2'b00, 2'b01);
    ex_branch_taken = 1'b1;
    #1;
    chk("br_ifid_flush", ifid_flush,  1);
    chk("br_bubble",     idex_bubble, 1);
    chk("br_pc_write",   pc_write,    1);
    tick();
    ex_branch_taken = 1'b0;
    idle();
    #1;
    chk("br_flush_cnt",  flush_count, 1);
    chk("br_flush_done", ifid_flush,  0);

    // jr alone: flush without bubble
    set_id(1, 5'd31, 5'd0, 0, 5'd0, 0, 2'b00, 2'b00, 2'b11);
    #1;
    chk("jr_flush",  ifid_flush,  1);
    chk("jr_bubble", idex_bubble, 0);
    chk("jr_pc",     pc_write,    1);
    tick();
    idle();
    #1;
    chk("jr_flush_cnt", flush_count, 2);
    tick();
    tick();
    tick();

    // sw stuck in MEM for 3 cycles; add $13 sits in WB when the wait starts
    set_id(1, 5'd0, 5'd0, 0, 5'd13, 1, 2'b00, 2'b00, 2'b00);
    tick();
    set_id(1, 5'd1, 5'd2, 1, 5'd0, 0, 2'b00, 2'b01, 2'b00);
    tick();
    set_id(1, 5'd13, 5'd13, 1, 5'd14, 1, 2'b00, 2'b00, 2'b00);
    tick();
    dmem_ready = 1'b0;
    #1;
    chk("w1_freeze",    pipe_freeze, 1);
    chk("w1_pc_write",  pc_write,    0);
    chk("w1_ifid_wr",   ifid_write,  0);
    chk("w1_fwd_a_wb",  fwd_a,       2'b01);
    tick();
    chk("w2_freeze",    pipe_freeze, 1);
    chk("w2_wb_invalid", fwd_a,      2'b00);
    tick();
    chk("w3_freeze",    pipe_freeze, 1);
    tick();
    dmem_ready = 1'b1;
    #1;
    chk("w_end_freeze", pipe_freeze,  0);
    chk("w_end_pc",     pc_write,     1);
    chk("w_stall_cnt",  stall_cycles, 4);
    tick();
    idle();
    tick();
    tick();
    tick();

    // reset during a memory wait
    set_id(1, 5'd1, 5'd2, 1, 5'd0, 0, 2'b00, 2'b01, 2'b00);
    tick();
    idle();
    tick();
    dmem_ready = 1'b0;
    #1;
    chk("rw_freeze", pipe_freeze, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rw_pc_write",  pc_write,     1);
    chk("rw_freeze_0",  pipe_freeze,  0);
    chk("rw_stall_cnt", stall_cycles, 0);
    chk("rw_flush_cnt", flush_count,  0);
    dmem_ready = 1'b1;
    tick();

    // long wait to saturate the 4-bit stall counter
    set_id(1, 5'd1, 5'd0, 0, 5'd3, 1, 2'b01, 2'b00, 2'b00);
    tick();
    idle();
    tick();
    dmem_ready = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("sat_at_15",   stall_cycles, 15);
    chk("sat_pc_low",  pc_write,     0);
    tick();
    chk("sat_hold_15", stall_cycles, 15);
    dmem_ready = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS datapath (IF, ID, EX, MEM, WB).
- Keeps a shadow copy of destination/control state for EX, MEM and WB. From it, the block generates:
  - PC and IF/ID write enables
  - IF/ID flush and ID/EX bubble insertion
  - a full-pipeline freeze while data memory is busy
  - ALU operand forwarding selects
- Sits beside the main decoder. Consumes decoded ID-stage fields plus branch resolution from EX.
- Exposes saturating stall and flush performance counters.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 16, performance counter width.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset; synchronous, active-high.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  REG_AW  ID source register A.
- id_rt  in  REG_AW  ID source register B.
- id_uses_rt  in  1  ID instruction reads rt as an operand.
- id_dst  in  REG_AW  ID destination, already muxed by RegDst.
- id_regwrite  in  1  ID instruction writes the register file.
- id_memread  in  2  decoder MemRead code (00 none, 01 lw, 10 lb, 11 lh).
- id_memwrite  in  2  decoder MemWrite code (00 none, else store).
- id_jump  in  2  decoder Jump code (00 none, 01 j, 10 jal, 11 jr).
- ex_branch_taken  in  1  branch in EX resolved taken.
- dmem_ready  in  1  data memory finished the current access.
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID register enable.
- ifid_flush  out  1  zero IF/ID contents.
- idex_bubble  out  1  load NOP controls into ID/EX.
- pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
- fwd_a  out  2  EX operand A select.
- fwd_b  out  2  EX operand B select.
- stall_cycles  out  CNT_W  cycles with pc_write=0.
- flush_count  out  CNT_W  flush events.

Behaviour:
- Shadow stages: EX, MEM and WB each hold {valid, dst, regwrite, is_load, is_mem}. EX also holds {rs, rt}.
- On reset, all valids clear and both counters clear. Shadow stages then advance on the next edge.
- Resulting idle outputs: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, pipe_freeze=0, fwd_a=fwd_b=00.
- Hazard outputs are combinational from shadow state plus inputs, with zero latency. Shadow stages update on clk.
- Conditions, highest priority first:
  1. MEM_WAIT: MEM.valid && MEM.is_mem && !dmem_ready.
     - Outputs: pc_write=0, ifid_write=0, pipe_freeze=1.
     - No shadow stage advances, except WB, which loads an invalid entry.
     - Persists for any number of cycles.
  2. BRANCH_FLUSH: ex_branch_taken.
     - Outputs: ifid_flush=1, idex_bubble=1, pc_write=1.
     - EX shadow loads invalid.
     - flush_count increments by 1.
  3. LOAD_USE: id_valid && EX.valid && EX.is_load && EX.dst!=0, and (EX.dst==id_rs, or (id_uses_rt && EX.dst==id_rt)).
     - Outputs: pc_write=0, ifid_write=0, idex_bubble=1.
     - EX shadow loads invalid. Lasts exactly 1 cycle, since the load then moves to MEM.
  4. JUMP_FLUSH: id_valid && id_jump!=00.
     - Outputs: ifid_flush=1, pc_write=1.
     - flush_count increments by 1.
- Simultaneous events:
  - A branch flush masks a coincident load-use or jump; only one flush is counted.
  - MEM_WAIT masks everything; the branch is re-evaluated after the wait ends because EX is held.
- Shadow advance (no freeze):
  - WB<=MEM, MEM<=EX.
  - EX<=ID fields, with valid=id_valid, unless a bubble is inserted.
  - is_load = id_memread!=00; is_mem = is_load || id_memwrite!=00.
- Forwarding (fwd_a for EX.rs, fwd_b for EX.rt):
  - 10 when MEM.valid && MEM.regwrite && MEM.dst!=0 && MEM.dst==src.
  - Else 01 when the same condition holds on WB.
  - Else 00.
  - MEM has priority over WB. Register 0 is never forwarded.
- Counters:
  - stall_cycles increments every cycle that pc_write=0.
  - Both counters saturate at all-ones and do not wrap.
- Reset mid-stall or mid-wait: the next cycle shows the idle outputs.

Decomposition:
- Shared package pipe_pkg holds:
  - FWD_REG=00, FWD_WB=01, FWD_MEM=10
  - JUMP_* and MEMRD_* codes matching the decoder
  - the shadow-stage struct/field widths
- One natural sub-module, sat_counter (CNT_W, inc, clear). It is instantiated twice.

Test Plan:
- Load-use: lw $8 in EX, ID add with rs=8 -> 1 cycle with pc_write=0 and idex_bubble=1; next cycle fwd_a=01; stall_cycles=1.
- Back-to-back ALU, add $9 then sub rt=9 -> fwd_b=10 with no stall. If rd=0, then fwd_b=00.
- Taken branch in EX with a coincident jump in ID -> ifid_flush=1 and idex_bubble=1 for 1 cycle; flush_count=1.
- sw in MEM with dmem_ready low for 3 cycles -> pipe_freeze=1 for 3 cycles and stall_cycles=3; WB valid=0 afterwards; resumes on ready.
- Reset asserted during a wait -> next cycle pc_write=1, pipe_freeze=0, counters 0.
- Preload stall_cycles to all-ones (CNT_W=4, 15 stalls) -> 16th stall holds the value at 15.
